// File: rtl/lock_sequencer_if.sv
// Timer handshake between the lock sequencer (master) and the seconds countdown timer (slave).
interface lock_sequencer_if;
    logic       timer_start;
    logic [9:0] timer_seconds;
    logic       timer_done;

    modport master (
        output timer_start,
        output timer_seconds,
        input  timer_done
    );

    modport slave (
        input  timer_start,
        input  timer_seconds,
        output timer_done
    );
endinterface

// File: rtl/lock_sequencer.sv
// Canal-lock control FSM: sequences gates, valves and the countdown timer for boat trips.
// Optional emergency stop (estop port, HALT state) enabled by defining LOCK_ESTOP_EN.
module lock_sequencer #(
    parameter int unsigned GATE_SECS  = 300,
    parameter int unsigned FILL_SECS  = 420,
    parameter int unsigned DRAIN_SECS = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arrive_low,
    input  logic       arrive_high,
    input  logic       boat_in_lock,
`ifdef LOCK_ESTOP_EN
    input  logic       estop,
`endif
    lock_sequencer_if.master tmr,
    output logic       gate_low_open,
    output logic       gate_high_open,
    output logic       fill_valve,
    output logic       drain_valve,
    output logic       level_high,
    output logic [2:0] state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PREADJ = 3'd1;
    localparam logic [2:0] ENTRY  = 3'd2;
    localparam logic [2:0] ADJUST = 3'd3;
    localparam logic [2:0] EXIT   = 3'd4;
`ifdef LOCK_ESTOP_EN
    localparam logic [2:0] HALT   = 3'd5;
    logic [2:0] halt_from;
`endif

    logic [2:0] nxt;
    logic       toggle;
    logic       pend_low;
    logic       pend_high;
    logic [1:0] blank;
    logic       expire;
    logic       req_low;
    logic       req_high;
    logic       cur_req;
    logic       opp_req;
    logic       start_q;
    logic [9:0] secs_q;
    logic       start_d;
    logic [9:0] secs_d;
    logic       gl_d;
    logic       gh_d;
    logic       fv_d;
    logic       dv_d;
    logic       clr_low;
    logic       clr_high;

    function automatic logic timed(input logic [2:0] s);
        return (s == PREADJ) || (s == ENTRY) ||
               (s == ADJUST) || (s == EXIT);
    endfunction

    assign req_low  = pend_low | arrive_low;
    assign req_high = pend_high | arrive_high;
    assign cur_req  = level_high ? req_high : req_low;
    assign opp_req  = level_high ? req_low : req_high;

    // Blanking covers the timer's reload latency after each start pulse
    assign expire = timed(state) && tmr.timer_done && (blank == 2'd0);

    assign tmr.timer_start   = start_q;
    assign tmr.timer_seconds = secs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            level_high     <= 1'b0;
            pend_low       <= 1'b0;
            pend_high      <= 1'b0;
            blank          <= 2'd0;
            start_q        <= 1'b0;
            secs_q         <= 10'd0;
            gate_low_open  <= 1'b0;
            gate_high_open <= 1'b0;
            fill_valve     <= 1'b0;
            drain_valve    <= 1'b0;
`ifdef LOCK_ESTOP_EN
            halt_from      <= IDLE;
`endif
        end else begin
            state          <= nxt;
            level_high     <= level_high ^ toggle;
            pend_low       <= clr_low ? 1'b0 : req_low;
            pend_high      <= clr_high ? 1'b0 : req_high;
            start_q        <= start_d;
            gate_low_open  <= gl_d;
            gate_high_open <= gh_d;
            fill_valve     <= fv_d;
            drain_valve    <= dv_d;
            if (start_d) begin
                secs_q <= secs_d;
                blank  <= 2'd2;
            end else if (blank != 2'd0) begin
                blank  <= blank - 2'd1;
            end
`ifdef LOCK_ESTOP_EN
            if (nxt == HALT && state != HALT)
                halt_from <= state;
`endif
        end
    end

    always_comb begin
        nxt    = state;
        toggle = 1'b0;
        unique case (state)
            IDLE: begin
                if (cur_req)
                    nxt = ENTRY;
                else if (opp_req)
                    nxt = PREADJ;
            end
            PREADJ: begin
                if (expire) begin
                    nxt    = ENTRY;
                    toggle = 1'b1;
                end
            end
            ENTRY: begin
                if (expire)
                    nxt = boat_in_lock ? ADJUST : IDLE;
            end
            ADJUST: begin
                if (expire) begin
                    nxt    = EXIT;
                    toggle = 1'b1;
                end
            end
            EXIT: begin
                if (expire && !boat_in_lock)
                    nxt = IDLE;
            end
`ifdef LOCK_ESTOP_EN
            HALT: begin
                if (!estop)
                    nxt = (halt_from == ADJUST || halt_from == PREADJ) ?
                          halt_from : IDLE;
            end
`endif
            default: nxt = IDLE;
        endcase
`ifdef LOCK_ESTOP_EN
        if (estop) begin
            nxt    = HALT;
            toggle = 1'b0;
        end
`endif
    end

    always_comb begin
        start_d  = (timed(nxt) && nxt != state) ||
                   (state == EXIT && nxt == EXIT && expire);
        secs_d   = (nxt == ENTRY || nxt == EXIT) ? 10'(GATE_SECS) :
                   level_high ? 10'(DRAIN_SECS) : 10'(FILL_SECS);
        // Entry side is the level after any PREADJ toggle on this edge
        clr_low  = (nxt == ENTRY) && (state != ENTRY) && !(level_high ^ toggle);
        clr_high = (nxt == ENTRY) && (state != ENTRY) && (level_high ^ toggle);
        gl_d     = (state == ENTRY || state == EXIT) && !level_high;
        gh_d     = (state == ENTRY || state == EXIT) && level_high;
        fv_d     = (state == PREADJ || state == ADJUST) && !level_high;
        dv_d     = (state == PREADJ || state == ADJUST) && level_high;
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed-vector bench for lock_sequencer; the bench drives timer_done directly.
module tb_lock_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       arrive_low;
    logic       arrive_high;
    logic       boat;
`ifdef LOCK_ESTOP_EN
    logic       estop;
`endif
    logic       gl;
    logic       gh;
    logic       fv;
    logic       dv;
    logic       lh;
    logic [2:0] st;
    int         checks   = 0;
    int         failures = 0;

    lock_sequencer_if ifc ();

    lock_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .arrive_low     (arrive_low),
        .arrive_high    (arrive_high),
        .boat_in_lock   (boat),
`ifdef LOCK_ESTOP_EN
        .estop          (estop),
`endif
        .tmr            (ifc.master),
        .gate_low_open  (gl),
        .gate_high_open (gh),
        .fill_valve     (fv),
        .drain_valve    (dv),
        .level_high     (lh),
        .state          (st)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two settle cycles clear the blanking window, then one done cycle
    task automatic expire();
        step();
        step();
        ifc.timer_done = 1'b1;
        step();
        ifc.timer_done = 1'b0;
    endtask

    always @(negedge clk) begin
        check("inv", {29'd0, gl & gh, fv & dv, (gl | gh) & (fv | dv)}, 0);
    end

    initial begin
        reset = 1'b0;
        arrive_low = 1'b0;
        arrive_high = 1'b0;
        boat = 1'b0;
        ifc.timer_done = 1'b0;
`ifdef LOCK_ESTOP_EN
        estop = 1'b0;
`endif
        step();
        step();
        check("rst_state", st, 0);
        check("rst_outs", {gl, gh, fv, dv, lh}, 0);
        check("rst_start", ifc.timer_start, 0);
        check("rst_secs", ifc.timer_seconds, 0);
        reset = 1'b1;
        step();
        check("idle", st, 0);

        // 1: low request at low level
        arrive_low = 1'b1;
        step();
        arrive_low = 1'b0;
        check("t1_state", st, 2);
        check("t1_start", ifc.timer_start, 1);
        check("t1_secs", ifc.timer_seconds, 300);
        check("t1_gl_lat", gl, 0);
        step();
        check("t1_start_end", ifc.timer_start, 0);
        check("t1_gl", gl, 1);

        // 2: full low->high trip
        boat = 1'b1;
        expire();
        check("t2_adj", st, 3);
        check("t2_start", ifc.timer_start, 1);
        check("t2_secs", ifc.timer_seconds, 420);
        step();
        check("t2_fill", {gl, fv, dv}, 3'b010);
        expire();
        check("t2_exit", st, 4);
        check("t2_lh", lh, 1);
        check("t2_secs_exit", ifc.timer_seconds, 300);
        step();
        check("t2_gh", {gh, fv}, 2'b10);
        boat = 1'b0;
        expire();
        check("t2_idle", st, 0);
        step();
        step();
        step();
        check("t2_pend_clr", st, 0);
        check("t2_gates_shut", {gl, gh}, 0);

        // 3: high request at low level
        reset = 1'b0;
        #1;
        reset = 1'b1;
        step();
        arrive_high = 1'b1;
        step();
        arrive_high = 1'b0;
        check("t3_preadj", st, 1);
        check("t3_secs", ifc.timer_seconds, 420);
        step();
        check("t3_fill", fv, 1);
        expire();
        check("t3_entry", st, 2);
        check("t3_lh", lh, 1);
        check("t3_secs_gate", ifc.timer_seconds, 300);
        step();
        check("t3_gh", {gh, fv}, 2'b10);
        expire();
        check("t3_abandon", st, 0);
        check("t3_lh_keep", lh, 1);

        // 5: done held across start pulses, level high
        ifc.timer_done = 1'b1;
        step();
        check("t5_idle_ign", st, 0);
        arrive_high = 1'b1;
        step();
        arrive_high = 1'b0;
        boat = 1'b1;
        check("t5_entry", st, 2);
        step();
        check("t5_blank1", st, 2);
        step();
        check("t5_blank2", st, 2);
        step();
        check("t5_adj", st, 3);
        check("t5_drain_secs", ifc.timer_seconds, 480);
        step();
        check("t5_dv", dv, 1);
        step();
        step();
        check("t5_exit", st, 4);
        check("t5_lh", lh, 0);
        step();
        step();
        step();
        check("t5_repulse_st", st, 4);
        check("t5_repulse", ifc.timer_start, 1);
        boat = 1'b0;
        step();
        check("t5_pulse_end", ifc.timer_start, 0);
        step();
        check("t5_blank3", st, 4);
        step();
        check("t5_idle", st, 0);
        ifc.timer_done = 1'b0;

        // 4: simultaneous requests at low level
        arrive_low = 1'b1;
        arrive_high = 1'b1;
        step();
        arrive_low = 1'b0;
        arrive_high = 1'b0;
        check("t4_entry", st, 2);
        step();
        check("t4_low_side", {gl, gh}, 2'b10);
        boat = 1'b1;
        expire();
        expire();
        check("t4_exit_lh", lh, 1);
        boat = 1'b0;
        expire();
        check("t4_idle", st, 0);
        step();
        check("t4_pend_high", st, 2);
        check("t4_start", ifc.timer_start, 1);
        step();
        check("t4_high_side", {gl, gh}, 2'b01);
        expire();
        step();
        step();
        check("t4_served", st, 0);

        // 6: reset mid-ADJUST at high level
        arrive_high = 1'b1;
        step();
        arrive_high = 1'b0;
        boat = 1'b1;
        expire();
        step();
        check("t6_adj", {st, dv, lh}, {3'd3, 2'b11});
        reset = 1'b0;
        #1;
        check("t6_rst_st", st, 0);
        check("t6_rst_outs", {gl, gh, fv, dv, lh, ifc.timer_start}, 0);
        step();
        reset = 1'b1;
        boat = 1'b0;

`ifdef LOCK_ESTOP_EN
        arrive_low = 1'b1;
        step();
        arrive_low = 1'b0;
        boat = 1'b1;
        expire();
        step();
        check("es_fill", fv, 1);
        estop = 1'b1;
        step();
        check("es_halt", st, 5);
        check("es_nostart", ifc.timer_start, 0);
        step();
        check("es_valves", {fv, dv, gl, gh}, 0);
        estop = 1'b0;
        step();
        check("es_resume", st, 3);
        check("es_start", ifc.timer_start, 1);
        check("es_secs", ifc.timer_seconds, 420);
        step();
        check("es_fill2", fv, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
